// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch stage.
//
// Contents:
//   FAULT_NONE / FAULT_MISALIGN / FAULT_RANGE  2-bit fault codes
//   DEFAULT_RESET_PC                           PC loaded on reset unless overridden
//   WORD_BYTES                                 fetch step in bytes
//   fetch_entry_t                              {pc, instr} pair buffered toward decode

package ifetch_pkg;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_RANGE    = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry synchronous FIFO of fetch entries.
//
// Ports:
//   clk    in   core clock, rising edge
//   rst_n  in   asynchronous active-low reset; empties the FIFO and zeroes storage
//   push   in   write wdata at the tail (caller guarantees space, or a pop in the same cycle)
//   pop    in   advance the head (caller guarantees the FIFO is not empty)
//   flush  in   empty the FIFO; overrides push and pop
//   wdata  in   entry to write
//   rdata  out  entry at the head (meaningful only while count != 0)
//   count  out  number of valid entries, 0..DEPTH
//
// DEPTH must be a power of two >= 2 so the pointers wrap by natural overflow.

import ifetch_pkg::*;

module ifetch_fifo #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [AW:0]  count
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [AW:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= wdata;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[head_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction-fetch stage. Owns the PC, addresses the combinational
// instruction memory and buffers {pc, word} pairs toward decode with valid/ready.
//
// Ports:
//   clk             in   core clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   imem_addr       out  byte address to instruction memory (the PC register)
//   imem_rdata      in   word returned combinationally for imem_addr
//   redirect_valid  in   branch/JAL taken this cycle; flushes the FIFO, highest priority
//   redirect_pc     in   redirect target
//   out_valid       out  FIFO head valid toward decode (forced low during a redirect)
//   out_ready       in   decode accepts the head
//   out_instr       out  head instruction word
//   out_pc          out  head PC
//   fault           out  sticky fetch fault
//   fault_code      out  FAULT_NONE / FAULT_MISALIGN / FAULT_RANGE
//   fault_pc        out  offending address
//   halted          out  sticky halt on a fetched zero word
//
// Optional feature macro FETCH_HALT_EN: when defined, a fetched all-zero word is not
// pushed and sets halted; fetching stops and the FIFO drains. When undefined, zero
// words are ordinary instructions and halted is tied 0.

import ifetch_pkg::*;

module ifetch_stage #(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_BYTES = 1048576,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] fault_pc,
    output logic        halted
);

    localparam int unsigned CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    // Highest word-aligned address that may be fetched.
    localparam logic [31:0] PC_LAST   = 32'(IMEM_BYTES - 4);

    logic [31:0]   pc_q, pc_d;
    logic          fault_q, fault_d;
    logic [1:0]    fault_code_q, fault_code_d;
    logic [31:0]   fault_pc_q, fault_pc_d;

    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  tail_entry;

    logic          pop;
    logic          push;
    logic          pc_legal;
    logic          has_space;
    logic          fetch_try;
    logic          range_hit;
    logic          halt_state;
    logic          halt_hit;

    // ------------------------------------------------------------------
    // Fetch decision
    // ------------------------------------------------------------------
    assign pc_legal  = (pc_q <= PC_LAST);
    assign has_space = (count < FULL_CNT) | pop;
    // A fetch is considered only when nothing upstream blocks it this cycle.
    assign fetch_try = !redirect_valid && !fault_q && !halt_state;
    assign range_hit = fetch_try && !pc_legal;

`ifdef FETCH_HALT_EN
    logic halted_q;

    assign halt_hit   = fetch_try && pc_legal && has_space && (imem_rdata == 32'h0000_0000);
    assign halt_state = halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (halt_hit) begin
            halted_q <= 1'b1;
        end
    end

    assign halted = halted_q;
`else
    assign halt_hit   = 1'b0;
    assign halt_state = 1'b0;
    assign halted     = 1'b0;
`endif

    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = fetch_try && pc_legal && has_space && !halt_hit;

    // ------------------------------------------------------------------
    // PC and fault next state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        fault_pc_d   = fault_pc_q;

        if (redirect_valid) begin
            if (redirect_pc[1:0] == 2'b00) begin
                pc_d = redirect_pc;
            end else if (!fault_q) begin
                // The first fault is the one reported; later ones leave it intact.
                fault_d      = 1'b1;
                fault_code_d = FAULT_MISALIGN;
                fault_pc_d   = redirect_pc;
            end
        end else if (range_hit) begin
            fault_d      = 1'b1;
            fault_code_d = FAULT_RANGE;
            fault_pc_d   = pc_q;
        end else if (push) begin
            pc_d = pc_q + WORD_BYTES;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
            fault_pc_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FIFO
    // ------------------------------------------------------------------
    assign tail_entry = '{pc: pc_q, instr: imem_rdata};

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (tail_entry),
        .rdata (head),
        .count (count)
    );

    assign imem_addr  = pc_q;
    assign out_instr  = head.instr;
    assign out_pc     = head.pc;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign fault_pc   = fault_pc_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: scoreboard bench for ifetch_stage. Expected {pc, word} pairs are
// queued when a scenario is set up and compared as decode accepts each head entry.
// A second instance with a 16-byte memory exercises the range fault.

module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
    logic        fault, halted;
    logic [1:0]  fault_code;
    logic [31:0] fault_pc;

    logic [31:0] imem_addr2, imem_rdata2;
    logic        out_valid2, fault2, halted2;
    logic        out_ready2 = 1'b1;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic [31:0] out_instr2, out_pc2, fault_pc2;
    logic [1:0]  fault_code2;

    logic        zero_en = 1'b0;
    logic        mon_en  = 1'b0;
    logic        mon2_en = 1'b0;
    logic [63:0] q  [$];
    logic [63:0] q2 [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ifetch_stage u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .fault_code     (fault_code),
        .fault_pc       (fault_pc),
        .halted         (halted)
    );

    ifetch_stage #(
        .IMEM_BYTES (16)
    ) u_dut_small (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr2),
        .imem_rdata     (imem_rdata2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .out_valid      (out_valid2),
        .out_ready      (out_ready2),
        .out_instr      (out_instr2),
        .out_pc         (out_pc2),
        .fault          (fault2),
        .fault_code     (fault_code2),
        .fault_pc       (fault_pc2),
        .halted         (halted2)
    );

    // Memory image: every word nonzero and address-dependent, except 0x60 when zero_en.
    function automatic logic [31:0] word_at(input logic [31:0] a, input logic zen);
        if (zen && a == 32'h60) return 32'h0;
        return {a[23:0], 8'h13};
    endfunction

    assign imem_rdata  = (zero_en && imem_addr == 32'h60) ? 32'h0 : {imem_addr[23:0], 8'h13};
    assign imem_rdata2 = {imem_addr2[23:0], 8'h13};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        q.push_back({pc, word_at(pc, zero_en)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        mon_en         = 1'b0;
        mon2_en        = 1'b0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = ready;
        tick();
        tick();
    endtask

    // Wait (bounded) until the scoreboard queue has drained, then stop monitoring.
    task automatic drain(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        check(tag, q.size(), 0);
        mon_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("extra_valid", {31'b0, out_valid}, 32'h0);
            end else begin
                logic [63:0] e;
                e = q.pop_front();
                check("out_pc", out_pc, e[63:32]);
                check("out_instr", out_instr, e[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (mon2_en && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                check("extra_valid2", {31'b0, out_valid2}, 32'h0);
            end else begin
                logic [63:0] e;
                e = q2.pop_front();
                check("out_pc2", out_pc2, e[63:32]);
                check("out_instr2", out_instr2, e[31:0]);
            end
        end
    end

    initial begin
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_code", {30'b0, fault_code}, 32'h0);
        check("rst_fpc", fault_pc, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // Streaming from reset: 0,4,8,12 on consecutive cycles.
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) expect_fetch(32'(i * 4));
        mon_en = 1'b1;
        rst_n  = 1'b1;
        check("rel_valid", {31'b0, out_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s1_valid", {31'b0, out_valid}, 32'h1);
        end
        drain("s1_drain");

        // Backpressure: two entries held, PC stalls at 8, then drains in order.
        do_reset(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("bp_valid", {31'b0, out_valid}, 32'h1);
        check("bp_pc", out_pc, 32'h0);
        check("bp_addr", imem_addr, 32'h8);
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        mon_en    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_nogap", {31'b0, out_valid}, 32'h1);
            tick();
        end
        drain("bp_drain");

        // Redirect with a full FIFO: no stale PC may appear.
        do_reset(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        expect_fetch(32'h3C);
        expect_fetch(32'h40);
        mon_en         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3C;
        out_ready      = 1'b1;
        #1;
        check("redir_valid", {31'b0, out_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        check("redir_addr", imem_addr, 32'h3C);
        check("redir_empty", {31'b0, out_valid}, 32'h0);
        drain("redir_drain");

        // Misaligned redirect: sticky fault, no further pushes.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3E;
        #1;
        check("mis_valid", {31'b0, out_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        check("mis_fault", {31'b0, fault}, 32'h1);
        check("mis_code", {30'b0, fault_code}, 32'h1);
        check("mis_fpc", fault_pc, 32'h3E);
        for (int i = 0; i < 3; i++) tick();
        check("mis_nopush", {31'b0, out_valid}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h101;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("mis2_code", {30'b0, fault_code}, 32'h1);
        check("mis2_fpc", fault_pc, 32'h3E);
        check("mis2_valid", {31'b0, out_valid}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_fault", {31'b0, fault}, 32'h0);
        check("arst_code", {30'b0, fault_code}, 32'h0);
        check("arst_fpc", fault_pc, 32'h0);
        check("arst_valid", {31'b0, out_valid}, 32'h0);
        check("arst_pc", out_pc, 32'h0);
        check("arst_instr", out_instr, 32'h0);
        check("arst_addr", imem_addr, 32'h0);

        // Range fault on the 16-byte instance.
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) q2.push_back({32'(i * 4), word_at(32'(i * 4), 1'b0)});
        mon2_en = 1'b1;
        rst_n   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (q2.size() == 0) break;
            tick();
        end
        check("rng_drain", q2.size(), 0);
        for (int i = 0; i < 3; i++) tick();
        check("rng_fault", {31'b0, fault2}, 32'h1);
        check("rng_code", {30'b0, fault_code2}, 32'h2);
        check("rng_fpc", fault_pc2, 32'h10);
        check("rng_valid", {31'b0, out_valid2}, 32'h0);
        mon2_en = 1'b0;

        // Zero word at 0x60.
        zero_en = 1'b1;
        do_reset(1'b1);
        rst_n = 1'b1;
        tick();
        tick();
        for (int a = 32'h50; a <= 32'h5C; a += 4) expect_fetch(32'(a));
`ifndef FETCH_HALT_EN
        expect_fetch(32'h60);
        expect_fetch(32'h64);
`endif
        mon_en         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h50;
        tick();
        redirect_valid = 1'b0;
        drain("zero_drain");
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 4; i++) tick();
        check("halt_set", {31'b0, halted}, 32'h1);
        check("halt_valid", {31'b0, out_valid}, 32'h0);
        check("halt_addr", imem_addr, 32'h60);
`else
        check("halt_tied", {31'b0, halted}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
Instruction-fetch stage of the single-cycle RISC-V core. Owns the PC, drives the byte address into the combinational instruction memory, and captures the returned word with its PC. Buffers fetched words in a small FIFO toward decode with a valid/ready handshake. Handles branch/jump redirects, halts on address faults, and sits directly upstream of the instruction memory's consumer path.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
IMEM_BYTES, 1048576, instruction memory size in bytes; legal fetch range is 0 to IMEM_BYTES-4.
DEPTH, 2, fetch FIFO entries; power of two, at least 2.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_addr  out  32  byte address to instruction memory; equals the PC register.
imem_rdata  in  32  little-endian word returned combinationally for imem_addr.
redirect_valid  in  1  branch/JAL taken this cycle.
redirect_pc  in  32  redirect target.
out_valid  out  1  FIFO head valid toward decode.
out_ready  in  1  decode accepts head.
out_instr  out  32  head instruction word.
out_pc  out  32  head PC.
fault  out  1  sticky fetch fault.
fault_code  out  2  0 none, 1 misaligned redirect, 2 out of range.
fault_pc  out  32  offending address.
halted  out  1  sticky halt, zero word fetched; present only with FETCH_HALT_EN, otherwise tied 0.

Behaviour:
- Reset (asynchronous, rst_n=0) applies immediately:
  - pc=RESET_PC; FIFO empty.
  - out_valid=0; out_instr=0; out_pc=0.
  - fault=0; fault_code=0; fault_pc=0; halted=0.
- imem_addr = pc (combinational).
- pop = out_valid & out_ready.
- push = !redirect_valid & !fault & !halted & pc range-legal & (count<DEPTH | pop).
- On push: write {pc, imem_rdata} at the FIFO tail; pc <= pc+4, modulo 2^32.
- Latency: a word fetched in cycle N is visible at out_* in cycle N+1 when the FIFO was empty.
- Throughput: one word per cycle sustained while decode is ready, including when the FIFO is full and popping in the same cycle.
- FIFO ordering:
  - Head and tail pointers wrap modulo DEPTH.
  - count is clog2(DEPTH)+1 bits.
  - out_valid = (count!=0) & !redirect_valid.
- Redirect (redirect_valid=1), highest priority:
  - FIFO flushed; count<=0.
  - Any pop in that cycle is discarded; out_valid is forced 0 that cycle.
  - No push that cycle.
  - If redirect_pc[1:0]==0: pc<=redirect_pc.
  - Otherwise: fault<=1, fault_code<=1, fault_pc<=redirect_pc; pc unchanged.
- Range fault: if not already faulted and pc > IMEM_BYTES-4 while a fetch would otherwise be attempted:
  - fault<=1, fault_code<=2, fault_pc<=pc.
  - No push; entries already in the FIFO still drain.
- Fault is sticky until reset. A redirect after a fault still flushes the FIFO but does not clear the fault or change fault_code.
- Simultaneous redirect and range fault: redirect wins, and the range check applies to the new pc in later cycles.
- Reset mid-operation discards all FIFO contents; the first fetch after release is at RESET_PC.

Optional Feature:
FETCH_HALT_EN
- Defined: a fetched word equal to 32'h0000_0000 is not pushed; halted<=1 (sticky); fetching stops and the FIFO drains. A redirect flushes the FIFO but does not clear halted.
- Undefined: zero words are pushed like any other word; halted is tied 0.

Decomposition:
- Package ifetch_pkg:
  - FAULT_NONE/FAULT_MISALIGN/FAULT_RANGE 2-bit constants.
  - Default RESET_PC.
  - Word-size constant 4.
  - A fetch-entry struct {pc[31:0], instr[31:0]}.
- Sub-module ifetch_fifo: synchronous DEPTH-entry FIFO with push/pop/flush and count, async active-low reset. Clock and reset names match the parent.

Test Plan:
- Memory preloaded with words W0..W3 at 0,4,8,12, out_ready=1 after reset -> out_pc 0,4,8,12 on consecutive cycles starting one cycle after reset release, out_instr=W0..W3.
- out_ready=0 for 5 cycles -> exactly 2 entries held (pc 0,4) and imem_addr stalls at 8; raise out_ready -> 0,4,8 in order, no gap or duplicate.
- Redirect to 0x3C while FIFO holds 2 entries -> out_valid=0 that cycle; next out_pc=0x3C with no older PC appearing.
- Redirect to 0x3E -> fault=1, fault_code=1, fault_pc=0x3E, no further pushes; assert rst_n low -> all outputs return to reset values immediately.
- IMEM_BYTES=16, free-run from 0 -> pcs 0,4,8,12 delivered, then fault_code=2, fault_pc=16.
- With FETCH_HALT_EN, zero word at 0x60 -> words up to 0x5C delivered, halted=1, pc 0x60 never appears at out_pc.
